// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// MODE encodings and the counter-width helper.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_cell.sv
// One bit of the universal shift register.
// 4:1 next-state mux feeding an async-clear flop.
module shift_cell
    import shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       d,
    input  logic       r_in,
    input  logic       l_in,
    output logic       q
);

    logic nxt;

    // select the next value of this bit from the operation code
    always_comb begin
        nxt = q;
        unique case (mode)
            MODE_HOLD: nxt = q;
            MODE_SHR:  nxt = r_in;
            MODE_SHL:  nxt = l_in;
            MODE_LOAD: nxt = d;
        endcase
    end

    // bit storage; clear wins over everything
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register with saturating shift counter.
// Define SHIFT_REG_ROTATE_EN to add the ROT rotate input.
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     Enable,
    input  logic [1:0]               MODE,
    input  logic [WIDTH-1:0]         D,
    input  logic                     SR_IN,
    input  logic                     SL_IN,
`ifdef SHIFT_REG_ROTATE_EN
    input  logic                     ROT,
`endif
    output logic [WIDTH-1:0]         X,
    output logic                     SO_R,
    output logic                     SO_L,
    output logic [cnt_w(WIDTH)-1:0]  CNT,
    output logic                     DONE
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic          sr_feed;
    logic          sl_feed;
    logic          shift_op;
    logic          load_op;
    logic [CW-1:0] cnt_nxt;

`ifdef SHIFT_REG_ROTATE_EN
    assign sr_feed = ROT ? X[0] : SR_IN;
    assign sl_feed = ROT ? X[WIDTH-1] : SL_IN;
`else
    assign sr_feed = SR_IN;
    assign sl_feed = SL_IN;
`endif

    assign shift_op = Enable && ((MODE == MODE_SHR) || (MODE == MODE_SHL));
    assign load_op  = Enable && (MODE == MODE_LOAD);
    assign cnt_nxt  = CNT + CW'(1);

    assign SO_R = X[0];
    assign SO_L = X[WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic r_src;
        logic l_src;

        if (i == WIDTH - 1) begin : g_top
            assign r_src = sr_feed;
        end else begin : g_mid_r
            assign r_src = X[i+1];
        end

        if (i == 0) begin : g_bot
            assign l_src = sl_feed;
        end else begin : g_mid_l
            assign l_src = X[i-1];
        end

        shift_cell u_cell (
            .clk   (CLK),
            .clr_n (CLR),
            .en    (Enable),
            .mode  (MODE),
            .d     (D[i]),
            .r_in  (r_src),
            .l_in  (l_src),
            .q     (X[i])
        );
    end

    // shift counter saturating at WIDTH; DONE rises on the same edge
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            CNT  <= '0;
            DONE <= 1'b0;
        end else if (load_op) begin
            CNT  <= '0;
            DONE <= 1'b0;
        end else if (shift_op && (CNT != CNT_MAX)) begin
            CNT  <= cnt_nxt;
            DONE <= (cnt_nxt == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Scoreboard bench for shift_reg_universal (WIDTH=8).
// Works with or without SHIFT_REG_ROTATE_EN defined.
module tb_shift_reg_universal;

    localparam int W  = 8;
    localparam int CW = 4;

    logic         CLK = 1'b0;
    logic         CLR = 1'b1;
    logic         Enable = 1'b0;
    logic [1:0]   MODE = 2'b00;
    logic [W-1:0] D = '0;
    logic         SR_IN = 1'b0;
    logic         SL_IN = 1'b0;
`ifdef SHIFT_REG_ROTATE_EN
    logic         ROT = 1'b0;
`endif
    logic [W-1:0]  X;
    logic          SO_R;
    logic          SO_L;
    logic [CW-1:0] CNT;
    logic          DONE;

    shift_reg_universal #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .Enable (Enable),
        .MODE   (MODE),
        .D      (D),
        .SR_IN  (SR_IN),
        .SL_IN  (SL_IN),
`ifdef SHIFT_REG_ROTATE_EN
        .ROT    (ROT),
`endif
        .X      (X),
        .SO_R   (SO_R),
        .SO_L   (SO_L),
        .CNT    (CNT),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0]  x;
        logic [CW-1:0] cnt;
        logic          done;
        logic          sor;
        logic          sol;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // reference model: value as integer, shift count as integer
    int m_x = 0;
    int m_cnt = 0;

    function automatic void push(input string nm, input int x,
                                 input int c, input bit dn);
        exp_t e;
        e.x    = W'(x);
        e.cnt  = CW'(c);
        e.done = dn;
        e.sor  = x[0];
        e.sol  = x[W-1];
        q_exp.push_back(e);
        q_name.push_back(nm);
    endfunction

    function automatic void cmp(input string nm, input string fld,
                                input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
        end
    endfunction

    function automatic void model_step(input bit en, input int md,
                                       input int d, input bit sr,
                                       input bit sl, input bit rot);
        int b;
        int mask;
        mask = (1 << W) - 1;
        if (!en) return;
        case (md)
            1: begin
                b = rot ? (m_x & 1) : int'(sr);
                m_x = (m_x >> 1) | (b << (W - 1));
                if (m_cnt < W) m_cnt++;
            end
            2: begin
                b = rot ? ((m_x >> (W - 1)) & 1) : int'(sl);
                m_x = ((m_x << 1) | b) & mask;
                if (m_cnt < W) m_cnt++;
            end
            3: begin
                m_x = d & mask;
                m_cnt = 0;
            end
            default: ;
        endcase
    endfunction

    task automatic step(input bit en, input int md, input int d,
                        input bit sr, input bit sl, input bit rot,
                        input string nm);
        bit r;
        @(negedge CLK);
        Enable = en;
        MODE   = 2'(md);
        D      = W'(d);
        SR_IN  = sr;
        SL_IN  = sl;
`ifdef SHIFT_REG_ROTATE_EN
        ROT = rot;
        r = rot;
`else
        r = 1'b0;
        if (rot) r = 1'b0;
`endif
        @(posedge CLK);
        model_step(en, md, d, sr, sl, r);
        #1;
        push(nm, m_x, m_cnt, m_cnt == W);
    endtask

    task automatic pulse_clr(input string nm);
        @(negedge CLK);
        Enable = 1'b0;
        @(posedge CLK);
        #2;
        CLR = 1'b0;
        m_x = 0;
        m_cnt = 0;
        #1;
        push(nm, 0, 0, 1'b0);
        @(negedge CLK);
        #1;
        CLR = 1'b1;
    endtask

    // monitor: compare every pending expectation at each falling edge
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge CLK);
            while (q_exp.size() > 0) begin
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                cmp(nm, "X",    int'(X),    int'(e.x));
                cmp(nm, "CNT",  int'(CNT),  int'(e.cnt));
                cmp(nm, "DONE", int'(DONE), int'(e.done));
                cmp(nm, "SO_R", int'(SO_R), int'(e.sor));
                cmp(nm, "SO_L", int'(SO_L), int'(e.sol));
            end
        end
    end

    initial begin
        int md;
        int rot_exp;

        #1 CLR = 1'b0;
        #2 push("por", 0, 0, 1'b0);
        @(negedge CLK);
        #1 CLR = 1'b1;

        step(1, 3, 'hA5, 0, 0, 0, "clr_load");
        step(1, 1, 0, 0, 0, 0, "clr_shr");
        step(1, 1, 0, 0, 0, 0, "clr_shr");
        pulse_clr("clr_async");
        step(1, 2, 0, 0, 1, 0, "after_clr");

        step(1, 3, 'hA5, 0, 0, 0, "shr_load");
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 0, "shr");
        push("shr_end", 'h00, 8, 1'b1);

        pulse_clr("shl_clr");
        for (int i = 0; i < 3; i++) step(1, 2, 0, 0, 1, 0, "shl");
        push("shl_end", 'h07, 3, 1'b0);

        for (int i = 0; i < 4; i++) step(0, 3, 'hFF, 1, 1, 1, "hold_en0");
        push("hold_end", 'h07, 3, 1'b0);
        for (int i = 0; i < 2; i++) step(1, 0, 'hFF, 1, 1, 1, "hold_m00");

        step(1, 3, 'h5A, 0, 0, 0, "sat_load");
        for (int i = 0; i < 10; i++)
            step(1, int'($urandom_range(1, 2)), 0, 1'($urandom),
                 1'($urandom), 0, "sat_shift");
        push("sat_end", m_x, 8, 1'b1);
        step(1, 3, 'h3C, 0, 0, 0, "sat_reload");
        push("sat_reload_c", 'h3C, 0, 1'b0);

`ifdef SHIFT_REG_ROTATE_EN
        rot_exp = 'hC0;
`else
        rot_exp = 'h40;
`endif
        step(1, 3, 'h81, 0, 0, 0, "rot_load");
        step(1, 1, 0, 0, 0, 1, "rot_r");
        push("rot_r_c", rot_exp, 1, 1'b0);
`ifdef SHIFT_REG_ROTATE_EN
        rot_exp = 'h03;
`else
        rot_exp = 'h02;
`endif
        step(1, 3, 'h81, 0, 0, 0, "rot_load");
        step(1, 2, 0, 0, 0, 1, "rot_l");
        push("rot_l_c", rot_exp, 1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                pulse_clr("rnd_clr");
            end else begin
                case ($urandom_range(0, 9))
                    0:       md = 3;
                    1:       md = 0;
                    default: md = int'($urandom_range(1, 2));
                endcase
                step($urandom_range(0, 7) != 0, md, int'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), "rnd");
            end
        end

        repeat (3) @(negedge CLK);
        #1;
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", q_exp.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
